// File: rtl/apb_reg_slave_pkg.sv
// Shared definitions for the APB register completer: state encoding, bus
// geometry, STATUS field layout and the wait-state counter width.
package apb_pkg;

    localparam int APB_DW      = 32;
    localparam int ALIGN_SHIFT = 2;
    localparam int WR_CNT_LSB  = 0;
    localparam int ERR_CNT_LSB = 16;
    localparam int CNT_W       = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/apb_reg_slave_if.sv
// APB3 signal bundle between the AHB-to-APB bridge (master) and the
// register completer (slave).
interface apb_reg_slave_if;
    import apb_pkg::*;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [APB_DW-1:0] PADDR;
    logic [APB_DW-1:0] PWDATA;
    logic [APB_DW-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_wait_ctr.sv
// Wait-state counter: loaded at setup, counts down through the access phase
// and flags the edge at which PREADY must rise.
module apb_wait_ctr
    import apb_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    input  logic clr,
    output logic ready_set
);

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        ready_set = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d     = WAIT_LD;
            // Zero wait states: ready goes up together with the setup edge.
            ready_set = (WAIT_LD == '0);
        end else if (run && (cnt_q != '0)) begin
            cnt_d     = cnt_q - 1'b1;
            ready_set = (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_reg_slave.sv
// APB3 register completer: RW register bank plus a read-only STATUS word of
// saturating write/error counts, with fixed wait states and PSLVERR checking.
module apb_reg_slave
    import apb_pkg::*;
#(
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] RESET_VAL   = 32'h0
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    apb_reg_slave_if.slave                   apb,
    output logic [APB_DW*(NUM_REGS-1)-1:0]   reg_out
);

    localparam int         NUM_RW     = NUM_REGS - 1;
    localparam int         IDX_W      = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
    localparam logic [29:0] STATUS_IDX = 30'(NUM_REGS - 1);

    apb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [APB_DW-1:0] wdata_q, wdata_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [APB_DW-1:0] prdata_q, prdata_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [APB_DW-1:0] regs_q [NUM_RW];
    logic [APB_DW-1:0] regs_d [NUM_RW];

    logic [29:0]       in_idx;
    logic              in_err;
    logic              setup, complete, abort, reg_we;
    logic              ctr_run, ctr_clr, ctr_ready;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_wr, sel_err;
    logic [APB_DW-1:0] status_val, rd_val;

    assign in_idx = apb.PADDR[APB_DW-1:ALIGN_SHIFT];
    assign in_err = (in_idx >= 30'(NUM_REGS)) || (apb.PADDR[1:0] != 2'b00) ||
                    (apb.PWRITE && (in_idx == STATUS_IDX));

    assign setup    = (state_q == IDLE) && apb.PSEL && !apb.PENABLE;
    assign complete = (state_q == ACCESS) && apb.PSEL && apb.PENABLE && pready_q;
    assign abort    = (state_q == ACCESS) && !apb.PSEL;
    assign reg_we   = complete && wr_q && !err_q;
    assign ctr_run  = (state_q == ACCESS) && apb.PSEL && !pready_q;
    assign ctr_clr  = complete || abort;

    // With zero wait states the response is built from the live setup inputs;
    // otherwise from the values latched at setup.
    assign sel_idx = (state_q == IDLE) ? in_idx[IDX_W-1:0] : idx_q;
    assign sel_wr  = (state_q == IDLE) ? apb.PWRITE : wr_q;
    assign sel_err = (state_q == IDLE) ? in_err : err_q;

    always_comb begin
        status_val = '0;
        status_val[WR_CNT_LSB  +: 16] = wr_cnt_q;
        status_val[ERR_CNT_LSB +: 16] = err_cnt_q;
        rd_val = status_val;
        for (int i = 0; i < NUM_RW; i++) begin
            if (sel_idx == IDX_W'(i)) rd_val = regs_q[i];
        end
    end

    apb_wait_ctr #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_ctr (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .load      (setup),
        .run       (ctr_run),
        .clr       (ctr_clr),
        .ready_set (ctr_ready)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_d      = wr_q;
        err_d     = err_q;
        wdata_d   = wdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d = ACCESS;
                    idx_d   = in_idx[IDX_W-1:0];
                    wr_d    = apb.PWRITE;
                    err_d   = in_err;
                    wdata_d = apb.PWDATA;
                end
            end
            ACCESS: begin
                if (abort || complete) begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end
                if (complete) begin
                    if (err_q)     err_cnt_d = sat_inc(err_cnt_q);
                    else if (wr_q) wr_cnt_d  = sat_inc(wr_cnt_q);
                end
            end
            default: state_d = IDLE;
        endcase
        if (ctr_ready) begin
            pready_d  = 1'b1;
            pslverr_d = sel_err;
            prdata_d  = (sel_err || sel_wr) ? '0 : rd_val;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RW; i++) begin
            regs_d[i] = regs_q[i];
            if (reg_we && (idx_q == IDX_W'(i))) regs_d[i] = wdata_q;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
            for (int i = 0; i < NUM_RW; i++) regs_q[i] <= RESET_VAL;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
            for (int i = 0; i < NUM_RW; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;

    for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_reg_out
        assign reg_out[gi*APB_DW +: APB_DW] = regs_q[gi];
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Drives three completers (0, 1 and 3 wait states) with directed and random
// APB transfers and compares them against a word-level register model.
module tb_apb_reg_slave;

    localparam int NR  = 8;
    localparam int NRW = NR - 1;
    localparam int ND  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic              psel    [ND];
    logic              penable [ND];
    logic              pwrite  [ND];
    logic [31:0]       paddr   [ND];
    logic [31:0]       pwdata  [ND];
    logic [31:0]       prdata  [ND];
    logic              pready  [ND];
    logic              pslverr [ND];
    logic [32*NRW-1:0] reg_out [ND];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mregs [ND][NRW];
    int          m_wr  [ND];
    int          m_err [ND];

    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        localparam int WC = (gi == 0) ? 0 : ((gi == 1) ? 1 : 3);
        apb_reg_slave_if bus ();
        assign bus.PSEL    = psel[gi];
        assign bus.PENABLE = penable[gi];
        assign bus.PWRITE  = pwrite[gi];
        assign bus.PADDR   = paddr[gi];
        assign bus.PWDATA  = pwdata[gi];
        assign prdata[gi]  = bus.PRDATA;
        assign pready[gi]  = bus.PREADY;
        assign pslverr[gi] = bus.PSLVERR;
        apb_reg_slave #(.NUM_REGS(NR), .WAIT_CYCLES(WC), .RESET_VAL(32'h0)) dut (
            .HCLK    (clk),
            .HRESETn (rst_n),
            .apb     (bus),
            .reg_out (reg_out[gi])
        );
    end

    function automatic int wc_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < NRW; i++) mregs[d][i] = 32'h0;
            m_wr[d]  = 0;
            m_err[d] = 0;
        end
    endtask

    function automatic logic [31:0] m_status(input int d);
        logic [15:0] w, e;
        w = 16'(m_wr[d]);
        e = 16'(m_err[d]);
        return {e, w};
    endfunction

    function automatic logic [32*NRW-1:0] m_flat(input int d);
        logic [32*NRW-1:0] v;
        for (int i = 0; i < NRW; i++) v[i*32 +: 32] = mregs[d][i];
        return v;
    endfunction

    // Reference behaviour of one completed transfer: word index from the byte
    // address, error rules, register update and STATUS bookkeeping.
    task automatic model_apply(input int d, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata,
                               output logic [31:0] exp_rd, output logic exp_err);
        int idx;
        idx     = int'(addr >> 2);
        exp_err = (addr >= 32'(NR * 4)) || (addr[1:0] != 2'b00) || (wr && idx == NR - 1);
        exp_rd  = 32'h0;
        if (exp_err) begin
            if (m_err[d] < 65535) m_err[d]++;
        end else if (wr) begin
            mregs[d][idx] = wdata;
            if (m_wr[d] < 65535) m_wr[d]++;
        end else begin
            exp_rd = (idx == NR - 1) ? m_status(d) : mregs[d][idx];
        end
    endtask

    // One APB transfer; starts and ends 1 time unit after a rising edge.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit scramble,
                        output logic [31:0] rdata, output logic err,
                        output int cycles, output bit done);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = wdata;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        if (scramble) begin
            paddr[d]  = $urandom;
            pwdata[d] = $urandom;
        end
        cycles = 0;
        done   = 1'b0;
        rdata  = 32'h0;
        err    = 1'b0;
        while (!done && cycles < 40) begin
            cycles++;
            @(negedge clk);
            if (pready[d] === 1'b1) begin
                done  = 1'b1;
                rdata = prdata[d];
                err   = pslverr[d];
            end
            @(posedge clk); #1;
        end
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        $display("xfer dut%0d wait=%0d %s addr=%h wdata=%h -> rdata=%h pslverr=%0b acc_cycles=%0d done=%0b",
                 d, wc_of(d), wr ? "WR" : "RD", addr, wdata, rdata, err, cycles, done);
    endtask

    task automatic test_reset();
        logic [31:0] rd, exp_rd;
        logic        err, exp_err;
        int          cyc;
        bit          done;
        rst_n = 1'b0;
        for (int d = 0; d < ND; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = 32'h0; pwdata[d] = 32'h0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            n_checks++;
            if (pready[d] !== 1'b0) begin n_fail++; $display("FAIL reset_pready dut%0d: got %b want 0", d, pready[d]); end
            n_checks++;
            if (pslverr[d] !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr dut%0d: got %b want 0", d, pslverr[d]); end
            n_checks++;
            if (prdata[d] !== 32'h0) begin n_fail++; $display("FAIL reset_prdata dut%0d: got %h want 0", d, prdata[d]); end
            n_checks++;
            if (reg_out[d] !== m_flat(d)) begin n_fail++; $display("FAIL reset_reg_out dut%0d: got %h want %h", d, reg_out[d], m_flat(d)); end
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1, 1'b0, 32'h0, 32'h0, 1'b0, rd, err, cyc, done);
        model_apply(1, 1'b0, 32'h0, 32'h0, exp_rd, exp_err);
        n_checks++;
        if (!done || cyc != 2) begin n_fail++; $display("FAIL first_read_latency: got %0d access cycles (done=%0b) want 2", cyc, done); end
        n_checks++;
        if (rd !== exp_rd) begin n_fail++; $display("FAIL first_read_data: got %h want %h", rd, exp_rd); end
        n_checks++;
        if (err !== exp_err) begin n_fail++; $display("FAIL first_read_pslverr: got %b want %b", err, exp_err); end
    endtask

    task automatic test_write_read();
        logic [31:0] rd, exp_rd;
        logic        err, exp_err;
        int          cyc;
        bit          done;
        for (int d = 0; d < ND; d++) begin
            xfer(d, 1'b1, 32'h8, 32'hDEADBEEF, 1'b0, rd, err, cyc, done);
            model_apply(d, 1'b1, 32'h8, 32'hDEADBEEF, exp_rd, exp_err);
            n_checks++;
            if (!done || cyc != wc_of(d) + 1 || err !== exp_err) begin
                n_fail++; $display("FAIL wr8 dut%0d: cycles=%0d err=%b want cycles=%0d err=%b", d, cyc, err, wc_of(d) + 1, exp_err);
            end
            n_checks++;
            if (reg_out[d][95:64] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL reg_out2 dut%0d: got %h want deadbeef", d, reg_out[d][95:64]); end
            xfer(d, 1'b0, 32'h8, 32'h0, 1'b0, rd, err, cyc, done);
            model_apply(d, 1'b0, 32'h8, 32'h0, exp_rd, exp_err);
            n_checks++;
            if (rd !== exp_rd || err !== exp_err) begin n_fail++; $display("FAIL rd8 dut%0d: got %h/%b want %h/%b", d, rd, err, exp_rd, exp_err); end
            xfer(d, 1'b0, 32'h1C, 32'h0, 1'b0, rd, err, cyc, done);
            model_apply(d, 1'b0, 32'h1C, 32'h0, exp_rd, exp_err);
            n_checks++;
            if (rd !== exp_rd || err !== exp_err) begin n_fail++; $display("FAIL status_after_wr dut%0d: got %h/%b want %h/%b", d, rd, err, exp_rd, exp_err); end
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [5] = '{32'h1C, 32'h20, 32'h6, 32'h2, 32'h24};
        bit          wrs   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] rd, exp_rd;
        logic        err, exp_err;
        int          cyc;
        bit          done;
        for (int k = 0; k < 5; k++) begin
            xfer(1, wrs[k], addrs[k], 32'hA5A5_0000 + 32'(k), 1'b0, rd, err, cyc, done);
            model_apply(1, wrs[k], addrs[k], 32'hA5A5_0000 + 32'(k), exp_rd, exp_err);
            n_checks++;
            if (!done || err !== exp_err || rd !== 32'h0) begin
                n_fail++; $display("FAIL err_case addr=%h: pslverr=%b prdata=%h done=%0b want pslverr=%b prdata=0", addrs[k], err, rd, done, exp_err);
            end
            n_checks++;
            if (reg_out[1] !== m_flat(1)) begin n_fail++; $display("FAIL err_no_write addr=%h: reg_out=%h want %h", addrs[k], reg_out[1], m_flat(1)); end
        end
        xfer(1, 1'b0, 32'h1C, 32'h0, 1'b0, rd, err, cyc, done);
        model_apply(1, 1'b0, 32'h1C, 32'h0, exp_rd, exp_err);
        n_checks++;
        if (rd !== exp_rd || err !== 1'b0) begin n_fail++; $display("FAIL status_err_count: got %h/%b want %h/0", rd, err, exp_rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp_rd, addr, wdata;
        logic        err, exp_err;
        int          cyc;
        bit          done, wr;
        for (int d = 0; d < ND; d++) begin
            for (int k = 0; k < 25; k++) begin
                wr    = 1'($urandom_range(0, 1));
                addr  = 32'($urandom_range(0, 9)) * 4;
                if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
                wdata = $urandom;
                xfer(d, wr, addr, wdata, 1'b1, rd, err, cyc, done);
                model_apply(d, wr, addr, wdata, exp_rd, exp_err);
                n_checks++;
                if (!done || cyc != wc_of(d) + 1) begin n_fail++; $display("FAIL rand_latency dut%0d: got %0d want %0d", d, cyc, wc_of(d) + 1); end
                n_checks++;
                if (err !== exp_err) begin n_fail++; $display("FAIL rand_pslverr dut%0d addr=%h: got %b want %b", d, addr, err, exp_err); end
                if (!wr || exp_err) begin
                    n_checks++;
                    if (rd !== exp_rd) begin n_fail++; $display("FAIL rand_prdata dut%0d addr=%h: got %h want %h", d, addr, rd, exp_rd); end
                end
                n_checks++;
                if (reg_out[d] !== m_flat(d)) begin n_fail++; $display("FAIL rand_reg_out dut%0d: got %h want %h", d, reg_out[d], m_flat(d)); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, exp_rd, va, vb;
        logic        err, exp_err;
        int          cyc0, cyc1;
        bit          done0, done1;
        for (int d = 0; d < ND; d += 2) begin
            va = $urandom;
            vb = $urandom;
            xfer(d, 1'b1, 32'h0, va, 1'b0, rd, err, cyc0, done0);
            model_apply(d, 1'b1, 32'h0, va, exp_rd, exp_err);
            xfer(d, 1'b1, 32'h4, vb, 1'b0, rd, err, cyc1, done1);
            model_apply(d, 1'b1, 32'h4, vb, exp_rd, exp_err);
            n_checks++;
            if (!done0 || !done1 || cyc0 != wc_of(d) + 1 || cyc1 != wc_of(d) + 1) begin
                n_fail++; $display("FAIL b2b_latency dut%0d: got %0d,%0d want %0d", d, cyc0, cyc1, wc_of(d) + 1);
            end
            n_checks++;
            if (reg_out[d][63:0] !== {vb, va}) begin n_fail++; $display("FAIL b2b_regs dut%0d: got %h want %h", d, reg_out[d][63:0], {vb, va}); end
            xfer(d, 1'b0, 32'h0, 32'h0, 1'b0, rd, err, cyc0, done0);
            model_apply(d, 1'b0, 32'h0, 32'h0, exp_rd, exp_err);
            n_checks++;
            if (rd !== exp_rd) begin n_fail++; $display("FAIL b2b_read0 dut%0d: got %h want %h", d, rd, exp_rd); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd, exp_rd, old;
        logic        err, exp_err;
        int          cyc;
        bit          done;
        old = mregs[2][1];
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 32'h4; pwdata[2] = 32'h12345678;
        @(posedge clk); #1;
        psel[2] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pready[2] !== 1'b0) begin n_fail++; $display("FAIL abort_pready: got %b want 0", pready[2]); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (reg_out[2][63:32] !== old) begin n_fail++; $display("FAIL abort_no_write: got %h want %h", reg_out[2][63:32], old); end
        @(posedge clk); #1;
        $display("xfer dut2 wait=3 WR addr=00000004 wdata=12345678 -> aborted in first access cycle");
        xfer(2, 1'b0, 32'h4, 32'h0, 1'b0, rd, err, cyc, done);
        model_apply(2, 1'b0, 32'h4, 32'h0, exp_rd, exp_err);
        n_checks++;
        if (!done || cyc != 4 || rd !== exp_rd) begin n_fail++; $display("FAIL abort_next_read: got %h cycles=%0d want %h cycles=4", rd, cyc, exp_rd); end
        xfer(2, 1'b0, 32'h1C, 32'h0, 1'b0, rd, err, cyc, done);
        model_apply(2, 1'b0, 32'h1C, 32'h0, exp_rd, exp_err);
        n_checks++;
        if (rd !== exp_rd) begin n_fail++; $display("FAIL abort_status: got %h want %h", rd, exp_rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, exp_rd;
        logic        err, exp_err;
        int          cyc;
        bit          done;
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 32'h0; pwdata[2] = 32'hCAFEF00D;
        @(posedge clk); #1;
        penable[2] = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        psel[2] = 1'b0; penable[2] = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < ND; d++) begin
            n_checks++;
            if (pready[d] !== 1'b0 || reg_out[d] !== m_flat(d)) begin
                n_fail++; $display("FAIL midreset dut%0d: pready=%b reg_out=%h want 0 / %h", d, pready[d], reg_out[d], m_flat(d));
            end
        end
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        $display("xfer dut2 wait=3 WR addr=00000000 wdata=cafef00d -> cut by reset");
        xfer(2, 1'b0, 32'h0, 32'h0, 1'b0, rd, err, cyc, done);
        model_apply(2, 1'b0, 32'h0, 32'h0, exp_rd, exp_err);
        n_checks++;
        if (!done || cyc != 4 || rd !== exp_rd) begin n_fail++; $display("FAIL midreset_read: got %h cycles=%0d want %h cycles=4", rd, cyc, exp_rd); end
        xfer(2, 1'b0, 32'h1C, 32'h0, 1'b0, rd, err, cyc, done);
        model_apply(2, 1'b0, 32'h1C, 32'h0, exp_rd, exp_err);
        n_checks++;
        if (rd !== exp_rd) begin n_fail++; $display("FAIL midreset_status: got %h want %h", rd, exp_rd); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_errors();
        test_back_to_back();
        test_abort();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
